mixer_fade_sequencer: RTL and testbench

Controls the PAL 576i video mixer that blends source 0 (background) with source 1 (overlay). It accepts mix commands over a valid/ready handshake and holds each one until the next field boundary. It then applies key-on-black enable and ramps the blend weight linearly, one step per N fields. All outputs are registered, so mode changes never tear mid-field.

---
 rtl/mixer_fade_sequencer.sv | 155 +++++++++++++++
 tb/tb_mixer_fade_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mixer_fade_sequencer.sv
// mixer_fade_sequencer
// Field-synchronous sequencer for the PAL 576i background/overlay mixer.
// A command is taken over cmd_valid/cmd_ready and held until the next field
// edge. At that edge it applies the key-on-black enable, then ramps alpha one
// step toward the target every cmd_period field edges. Outputs only change on
// field edges, so the mixer never switches mode part-way through a field.
// Optional build macro MIXSEQ_FRAME_ALIGN_EN: a held command is applied only
// on an odd-field edge, which gives frame-aligned switching. The fade still
// steps on every field edge.
module mixer_fade_sequencer #(
    parameter int ALPHA_W  = 6,
    parameter int PERIOD_W = 8
) (
    input  logic                pixelClockX6,
    input  logic                nReset,
    input  logic                pixelClockX1_en,
    input  logic                vSyncIn,
    input  logic                fieldOdd,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_key,
    input  logic [ALPHA_W-1:0]  cmd_alpha,
    input  logic [PERIOD_W-1:0] cmd_period,
    input  logic                cmd_abort,
    output logic                keyEnable,
    output logic [ALPHA_W-1:0]  alpha,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {IDLE, ARMED, FADE} state_t;

    state_t              state;
    logic                vSyncPrev;
    logic                readyReg;
    logic                dirUp;
    logic [PERIOD_W-1:0] stepCount;

    logic                keyLat;
    logic [ALPHA_W-1:0]  targetLat;
    logic [PERIOD_W-1:0] periodLat;

    logic                fe;
    logic                accept;
    logic                armGate;
    logic [ALPHA_W-1:0]  nextAlpha;

    // One step toward the target in the direction fixed at arming. A value
    // already at or past the target clamps to it, so alpha can never wrap.
    function automatic logic [ALPHA_W-1:0] stepToward(
        input logic [ALPHA_W-1:0] cur,
        input logic [ALPHA_W-1:0] tgt,
        input logic               up
    );
        if (up)
            return (cur >= tgt) ? tgt : cur + ALPHA_W'(1);
        else
            return (cur <= tgt) ? tgt : cur - ALPHA_W'(1);
    endfunction

    assign fe        = pixelClockX1_en & vSyncIn & ~vSyncPrev;
    // An abort in the same cycle blocks acceptance of a new command.
    assign cmd_ready = readyReg & ~cmd_abort;
    assign accept    = pixelClockX1_en & cmd_valid & cmd_ready;
    assign nextAlpha = stepToward(alpha, targetLat, dirUp);

`ifdef MIXSEQ_FRAME_ALIGN_EN
    assign armGate = fieldOdd;
`else
    // Any field edge arms. fieldOdd is ORed in only so the port stays
    // connected; it does not change the result.
    assign armGate = 1'b1 | fieldOdd;
`endif

    // Command payload, captured on the accepted handshake and held until the sequence ends.
    always_ff @(posedge pixelClockX6) begin
        if (accept) begin
            keyLat    <= cmd_key;
            targetLat <= cmd_alpha;
            periodLat <= cmd_period;
        end
    end

    // Sequencer FSM: field-edge detect, arming, fade stepping and registered mixer outputs.
    always_ff @(posedge pixelClockX6 or negedge nReset) begin
        if (!nReset) begin
            state     <= IDLE;
            vSyncPrev <= 1'b0;
            readyReg  <= 1'b1;
            dirUp     <= 1'b0;
            stepCount <= '0;
            keyEnable <= 1'b0;
            alpha     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (pixelClockX1_en) begin
            vSyncPrev <= vSyncIn;
            done      <= 1'b0;
            if (cmd_abort) begin
                state    <= IDLE;
                busy     <= 1'b0;
                readyReg <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        // A field edge in the transfer cycle is deliberately not used.
                        if (accept) begin
                            state    <= ARMED;
                            busy     <= 1'b1;
                            readyReg <= 1'b0;
                        end
                    end
                    ARMED: begin
                        if (fe && armGate) begin
                            keyEnable <= keyLat;
                            if (periodLat == '0 || alpha == targetLat) begin
                                alpha    <= targetLat;
                                done     <= 1'b1;
                                state    <= IDLE;
                                busy     <= 1'b0;
                                readyReg <= 1'b1;
                            end else begin
                                stepCount <= periodLat;
                                dirUp     <= (targetLat > alpha);
                                state     <= FADE;
                            end
                        end
                    end
                    FADE: begin
                        if (fe) begin
                            if (stepCount == PERIOD_W'(1)) begin
                                alpha     <= nextAlpha;
                                stepCount <= periodLat;
                                if (nextAlpha == targetLat) begin
                                    done     <= 1'b1;
                                    state    <= IDLE;
                                    busy     <= 1'b0;
                                    readyReg <= 1'b1;
                                end
                            end else begin
                                stepCount <= stepCount - PERIOD_W'(1);
                            end
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        readyReg <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mixer_fade_sequencer.sv
// tb_mixer_fade_sequencer
// Scoreboard bench for mixer_fade_sequencer. Each command pushes the
// expected output state after every field edge it affects. The field-edge
// task pops one entry per edge and compares it against the DUT outputs.
// When the queue is empty, the sequencer is expected to sit idle and hold
// its last alpha/key.
module tb_mixer_fade_sequencer;

    localparam int ALPHA_W  = 6;
    localparam int PERIOD_W = 8;

    logic                pixelClockX6 = 1'b0;
    logic                nReset = 1'b0;
    logic                pixelClockX1_en = 1'b0;
    logic                vSyncIn = 1'b0;
    logic                fieldOdd = 1'b0;
    logic                cmd_valid = 1'b0;
    logic                cmd_ready;
    logic                cmd_key = 1'b0;
    logic [ALPHA_W-1:0]  cmd_alpha = '0;
    logic [PERIOD_W-1:0] cmd_period = '0;
    logic                cmd_abort = 1'b0;
    logic                keyEnable;
    logic [ALPHA_W-1:0]  alpha;
    logic                busy;
    logic                done;

    typedef struct {
        int alpha;
        int key;
        int busy;
        int done;
    } exp_t;

    exp_t sbq[$];
    int   nTests = 0;
    int   nFail  = 0;
    int   mAlpha = 0;
    int   mKey   = 0;
    logic oddNext = 1'b1;

    mixer_fade_sequencer #(.ALPHA_W(ALPHA_W), .PERIOD_W(PERIOD_W)) dut (
        .pixelClockX6    (pixelClockX6),
        .nReset          (nReset),
        .pixelClockX1_en (pixelClockX1_en),
        .vSyncIn         (vSyncIn),
        .fieldOdd        (fieldOdd),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_key         (cmd_key),
        .cmd_alpha       (cmd_alpha),
        .cmd_period      (cmd_period),
        .cmd_abort       (cmd_abort),
        .keyEnable       (keyEnable),
        .alpha           (alpha),
        .busy            (busy),
        .done            (done)
    );

    always #5 pixelClockX6 = ~pixelClockX6;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, limit 1000000", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic checkVal(input string tag, input int got, input int exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One enabled edge preceded by one disabled edge; returns 1 time unit after the enabled edge.
    task automatic tick();
        @(negedge pixelClockX6);
        pixelClockX1_en = 1'b0;
        @(negedge pixelClockX6);
        pixelClockX1_en = 1'b1;
        @(posedge pixelClockX6);
        #1;
    endtask

    task automatic checkOutputs(input string tag, input exp_t e);
        checkVal({tag, ".alpha"}, int'(alpha), e.alpha);
        checkVal({tag, ".key"},   int'(keyEnable), e.key);
        checkVal({tag, ".busy"},  int'(busy), e.busy);
        checkVal({tag, ".done"},  int'(done), e.done);
    endtask

    task automatic fieldEdge(input string tag);
        exp_t e;
        fieldOdd = oddNext;
        vSyncIn  = 1'b1;
        tick();
        if (sbq.size() > 0) e = sbq.pop_front();
        else e = '{mAlpha, mKey, 0, 0};
        checkOutputs(tag, e);
        checkVal({tag, ".ready"}, int'(cmd_ready), (e.busy != 0) ? 0 : 1);
        vSyncIn = 1'b0;
        oddNext = ~oddNext;
        tick();
        checkVal({tag, ".donePulse"}, int'(done), 0);
        tick();
    endtask

    // Expected state after each field edge from arming to completion.
    task automatic pushTrajectory(input int key, input int tgt, input int per);
        int a;
        int n;
        int al;
        bit up;
        bit last;
        a  = mAlpha;
        up = (tgt > a);
        n  = up ? tgt - a : a - tgt;
`ifdef MIXSEQ_FRAME_ALIGN_EN
        if (!oddNext) sbq.push_back('{mAlpha, mKey, 1, 0});
`endif
        if (per == 0 || n == 0) begin
            sbq.push_back('{tgt, key, 0, 1});
        end else begin
            sbq.push_back('{a, key, 1, 0});
            for (int k = 1; k <= n * per; k++) begin
                al   = up ? a + k / per : a - k / per;
                last = (k == n * per);
                sbq.push_back('{al, key, last ? 0 : 1, last ? 1 : 0});
            end
        end
        mAlpha = tgt;
        mKey   = key;
    endtask

    task automatic sendCmd(input string tag, input int key, input int tgt, input int per, input bit withFe);
        exp_t hold;
        cmd_key    = key[0];
        cmd_alpha  = ALPHA_W'(tgt);
        cmd_period = PERIOD_W'(per);
        cmd_valid  = 1'b1;
        if (withFe) begin
            fieldOdd = oddNext;
            vSyncIn  = 1'b1;
        end
        checkVal({tag, ".readyIdle"}, int'(cmd_ready), 1);
        tick();
        cmd_valid = 1'b0;
        hold = '{mAlpha, mKey, 1, 0};
        checkOutputs({tag, ".xfer"}, hold);
        if (withFe) begin
            vSyncIn = 1'b0;
            oddNext = ~oddNext;
        end
        tick();
        tick();
        checkOutputs({tag, ".midField"}, hold);
        checkVal({tag, ".readyArmed"}, int'(cmd_ready), 0);
        pushTrajectory(key, tgt, per);
    endtask

    initial begin
        // Reset and idle fields
        repeat (3) @(posedge pixelClockX6);
        #1;
        checkOutputs("rst", '{0, 0, 0, 0});
        checkVal("rst.ready", int'(cmd_ready), 1);
        @(negedge pixelClockX6);
        nReset = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) fieldEdge("idle");

        // Immediate command, key on, alpha 40
        sendCmd("imm", 1, 40, 0, 1'b0);
        fieldEdge("imm");
        fieldEdge("immAfter");

        // Back to 0, then full-range fade with period 2
        sendCmd("zero", 0, 0, 0, 1'b0);
        fieldEdge("zero");
        sendCmd("fadeUp", 0, 63, 2, 1'b0);
        while (sbq.size() > 0) fieldEdge("fadeUp");
        fieldEdge("fadeUpHold");

        // Downward fade 10 -> 7, command held during the fade is refused
        sendCmd("to10", 0, 10, 0, 1'b0);
        fieldEdge("to10");
        sendCmd("fadeDn", 0, 7, 1, 1'b0);
        fieldEdge("fadeDnArm");
        cmd_valid  = 1'b1;
        cmd_alpha  = ALPHA_W'(33);
        cmd_period = '0;
        fieldEdge("fadeDnHeld");
        cmd_valid = 1'b0;
        while (sbq.size() > 0) fieldEdge("fadeDn");

        // Abort at alpha 20 during a 0 -> 50 fade
        sendCmd("to0", 0, 0, 0, 1'b0);
        fieldEdge("to0");
        sendCmd("abortFade", 0, 50, 1, 1'b0);
        for (int i = 0; i < 21; i++) fieldEdge("abortFade");
        checkVal("abort.preAlpha", int'(alpha), 20);
        cmd_abort  = 1'b1;
        cmd_valid  = 1'b1;
        cmd_alpha  = ALPHA_W'(5);
        cmd_period = '0;
        #1;
        checkVal("abort.readyLow", int'(cmd_ready), 0);
        tick();
        cmd_abort = 1'b0;
        cmd_valid = 1'b0;
        checkOutputs("abort", '{20, 0, 0, 0});
        sbq.delete();
        mAlpha = 20;
        mKey   = 0;
        tick();
        checkVal("abort.readyBack", int'(cmd_ready), 1);
        checkVal("abort.noDone", int'(done), 0);
        for (int i = 0; i < 3; i++) fieldEdge("abortHold");

        // Transfer coincident with a field edge
        sendCmd("coinc", 1, 30, 0, 1'b1);
        while (sbq.size() > 0) fieldEdge("coinc");
        fieldEdge("coincHold");

        // Asynchronous reset in the middle of a fade
        sendCmd("rstFade", 0, 40, 3, 1'b0);
        for (int i = 0; i < 4; i++) fieldEdge("rstFade");
        checkVal("rstFade.alpha", int'(alpha), 31);
        #2;
        nReset = 1'b0;
        #1;
        checkOutputs("rstMid", '{0, 0, 0, 0});
        checkVal("rstMid.ready", int'(cmd_ready), 1);
        @(negedge pixelClockX6);
        nReset = 1'b1;
        sbq.delete();
        mAlpha = 0;
        mKey   = 0;
        for (int i = 0; i < 2; i++) fieldEdge("postRst");

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
